mac_tx_seq: RTL and testbench

//  Frame sequencer for the MAC TX path. It drives the mac_tx_framegen select strobes
//  (hdr/data/idle/ifg/error) and pops the TX frame buffer, so that each buffered frame

---
 rtl/mac_tx_seq.sv | 145 ++++++++++++++
 tb/tb_mac_tx_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_seq.sv
// MAC TX frame sequencer: walks each buffered frame through header, payload
// and inter-frame gap, turning underruns and bad words into an error word.
module mac_tx_seq #(
    parameter int HDR_WORDS = 1,
    parameter int W_HDR_CNT = 1,
    parameter int IFG_WORDS = 2,
    parameter int W_CNT     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_clk_en,
    input  logic                 i_tx_en,
    input  logic                 i_frame_rdy,
    input  logic                 i_buf_empty,
    input  logic                 i_buf_last,
    input  logic                 i_buf_err,
    output logic                 o_buf_rd,
    output logic                 o_gen_hdr,
    output logic [W_HDR_CNT-1:0] o_hdr_id,
    output logic                 o_gen_data,
    output logic                 o_gen_idle,
    output logic                 o_gen_ifg,
    output logic                 o_gen_error,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_underrun,
    output logic [W_CNT-1:0]     o_frame_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_IFG   = 3'd4;

    localparam int W_IFG = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;

    localparam logic [W_HDR_CNT-1:0] HDR_LAST = W_HDR_CNT'(HDR_WORDS - 1);
    localparam logic [W_IFG-1:0]     IFG_LAST = W_IFG'(IFG_WORDS - 1);

    logic [2:0]           state;
    logic [2:0]           state_nx;
    logic [W_HDR_CNT-1:0] hdr_cnt;
    logic [W_IFG-1:0]     ifg_cnt;
    logic [W_CNT-1:0]     frame_cnt;

    logic start_ok;
    logic word_ok;
    logic in_data;
    logic in_flush;
    logic hdr_end;
    logic ifg_end;
    logic pop_raw;
    logic good_end;

    assign start_ok = i_tx_en & i_frame_rdy;
    assign word_ok  = ~i_buf_empty;
    assign in_data  = (state == S_DATA);
    assign in_flush = (state == S_FLUSH);
    assign hdr_end  = (state == S_HDR) && (hdr_cnt == HDR_LAST);
    assign ifg_end  = (state == S_IFG) && (ifg_cnt == IFG_LAST);

    // last/err flags only mean anything while a word is actually readable
    assign pop_raw  = (in_data | in_flush) & word_ok;
    assign good_end = in_data & word_ok & ~i_buf_err & i_buf_last;

    assign o_buf_rd     = i_clk_en & pop_raw;
    assign o_frame_done = i_clk_en & pop_raw & i_buf_last;
    assign o_underrun   = i_clk_en & in_data & i_buf_empty;
    assign o_busy       = (state != S_IDLE);
    assign o_hdr_id     = hdr_cnt;
    assign o_frame_cnt  = frame_cnt;

    always_comb begin
        o_gen_hdr   = 1'b0;
        o_gen_data  = 1'b0;
        o_gen_idle  = 1'b0;
        o_gen_ifg   = 1'b0;
        o_gen_error = 1'b0;
        case (state)
            S_HDR:   o_gen_hdr = 1'b1;
            S_DATA: begin
                if (i_buf_empty || i_buf_err)
                    o_gen_error = 1'b1;
                else
                    o_gen_data = 1'b1;
            end
            S_IFG:   o_gen_ifg = 1'b1;
            default: o_gen_idle = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start_ok)
                    state_nx = S_HDR;
            end
            S_HDR: begin
                if (hdr_end)
                    state_nx = S_DATA;
            end
            S_DATA: begin
                if (i_buf_empty)
                    state_nx = S_FLUSH;
                else if (i_buf_last)
                    state_nx = S_IFG;
                else if (i_buf_err)
                    state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (word_ok && i_buf_last)
                    state_nx = S_IFG;
            end
            S_IFG: begin
                if (ifg_end)
                    state_nx = start_ok ? S_HDR : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_IDLE;
            hdr_cnt   <= '0;
            ifg_cnt   <= '0;
            frame_cnt <= '0;
        end else if (i_clk_en) begin
            state <= state_nx;
            if ((state == S_HDR) && !hdr_end)
                hdr_cnt <= hdr_cnt + W_HDR_CNT'(1);
            else
                hdr_cnt <= '0;
            if ((state == S_IFG) && !ifg_end)
                ifg_cnt <= ifg_cnt + W_IFG'(1);
            else
                ifg_cnt <= '0;
            if (good_end)
                frame_cnt <= frame_cnt + W_CNT'(1);
        end
    end

endmodule

// File: tb/tb_mac_tx_seq.sv
// Randomised scoreboard bench for mac_tx_seq: a frame-level model predicts
// the non-idle strobe/pop stream, a monitor compares it cycle by cycle.
module tb_mac_tx_seq;

    localparam int HW   = 1;
    localparam int WH   = 1;
    localparam int IFGW = 2;
    localparam int WC   = 3;
    localparam int CMOD = 1 << WC;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b1;
    logic          i_clk_en = 1'b1;
    logic          i_tx_en = 1'b1;
    logic          i_frame_rdy = 1'b0;
    logic          i_buf_empty = 1'b1;
    logic          i_buf_last = 1'b0;
    logic          i_buf_err = 1'b0;
    logic          o_buf_rd;
    logic          o_gen_hdr;
    logic [WH-1:0] o_hdr_id;
    logic          o_gen_data;
    logic          o_gen_idle;
    logic          o_gen_ifg;
    logic          o_gen_error;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_underrun;
    logic [WC-1:0] o_frame_cnt;

    always #5 i_clk = ~i_clk;

    mac_tx_seq #(
        .HDR_WORDS(HW),
        .W_HDR_CNT(WH),
        .IFG_WORDS(IFGW),
        .W_CNT(WC)
    ) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_clk_en(i_clk_en),
        .i_tx_en(i_tx_en),
        .i_frame_rdy(i_frame_rdy),
        .i_buf_empty(i_buf_empty),
        .i_buf_last(i_buf_last),
        .i_buf_err(i_buf_err),
        .o_buf_rd(o_buf_rd),
        .o_gen_hdr(o_gen_hdr),
        .o_hdr_id(o_hdr_id),
        .o_gen_data(o_gen_data),
        .o_gen_idle(o_gen_idle),
        .o_gen_ifg(o_gen_ifg),
        .o_gen_error(o_gen_error),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done),
        .o_underrun(o_underrun),
        .o_frame_cnt(o_frame_cnt)
    );

    // kind: 0 idle, 1 hdr, 2 data, 3 ifg, 4 error
    typedef struct {
        int kind;
        bit pop;
        bit done;
        bit und;
        int id;
        int cnt;
    } tok_t;

    typedef struct {
        bit last;
        bit err;
    } word_t;

    tok_t  exp_q[$];
    word_t buf_q[$];
    int    vis_lim = -1;
    int    rel_cd = 0;
    int    good_cnt = 0;
    int    en_mode = 0;
    bit    tx_rand = 1'b0;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int vis_words();
        if (vis_lim < 0)
            return buf_q.size();
        return (vis_lim < buf_q.size()) ? vis_lim : buf_q.size();
    endfunction

    function automatic bit frame_ready();
        foreach (buf_q[i])
            if (buf_q[i].last)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic tok_t mk(input int k, input bit p, input bit d, input bit u,
                                input int id, input int c);
        tok_t t;
        t.kind = k;
        t.pop = p;
        t.done = d;
        t.und = u;
        t.id = id;
        t.cnt = c % CMOD;
        return t;
    endfunction

    // e: index of bad word, u: index where the buffer runs dry (-1 = none)
    task automatic load_frame(input int n, input int e, input int u);
        int base;
        bit good;
        word_t w;
        base = buf_q.size();
        good = (e < 0) && (u < 0);
        for (int h = 0; h < HW; h++)
            exp_q.push_back(mk(1, 0, 0, 0, h, good_cnt));
        for (int i = 0; i < n; i++) begin
            if (i == u) begin
                exp_q.push_back(mk(4, 0, 0, 1, 0, good_cnt));
                for (int j = u; j < n; j++)
                    exp_q.push_back(mk(0, 1, j == n - 1, 0, 0, good_cnt));
                break;
            end
            if (i == e) begin
                exp_q.push_back(mk(4, 1, i == n - 1, 0, 0, good_cnt));
                for (int j = i + 1; j < n; j++)
                    exp_q.push_back(mk(0, 1, j == n - 1, 0, 0, good_cnt));
                break;
            end
            exp_q.push_back(mk(2, 1, i == n - 1, 0, 0, good_cnt));
        end
        if (good)
            good_cnt++;
        for (int g = 0; g < IFGW; g++)
            exp_q.push_back(mk(3, 0, 0, 0, 0, good_cnt));
        for (int i = 0; i < n; i++) begin
            w.last = (i == n - 1);
            w.err = (i == e);
            buf_q.push_back(w);
        end
        if (u >= 0)
            vis_lim = base + u;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || buf_q.size() != 0) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
            buf_q.delete();
            vis_lim = -1;
        end
        repeat (4) @(negedge i_clk);
        #3;
    endtask

    // buffer / environment driver
    initial begin
        forever begin
            @(negedge i_clk);
            case (en_mode)
                0: i_clk_en = 1'b1;
                1: i_clk_en = ~i_clk_en;
                default: i_clk_en = (($urandom % 4) != 0);
            endcase
            i_tx_en = tx_rand ? (($urandom % 6) != 0) : 1'b1;
            i_frame_rdy = frame_ready();
            if (vis_words() > 0) begin
                i_buf_empty = 1'b0;
                i_buf_last = buf_q[0].last;
                i_buf_err = buf_q[0].err;
            end else begin
                i_buf_empty = 1'b1;
                i_buf_last = 1'($urandom);
                i_buf_err = 1'($urandom);
            end
            #1;
            if (i_reset_n && i_clk_en) begin
                if (rel_cd > 0) begin
                    rel_cd--;
                    if (rel_cd == 0)
                        vis_lim = -1;
                end
                if (o_underrun)
                    rel_cd = $urandom_range(1, 4);
                if (o_buf_rd && buf_q.size() > 0) begin
                    void'(buf_q.pop_front());
                    if (vis_lim > 0)
                        vis_lim--;
                end
            end
        end
    end

    // monitor / scoreboard
    tok_t t;
    int   kind;
    int   ifg_run = 0;
    bit   b2b_due = 1'b0;

    initial begin
        forever begin
            @(negedge i_clk);
            #2;
            if (!i_reset_n) begin
                ifg_run = 0;
                b2b_due = 1'b0;
                continue;
            end
            check("onehot", $countones({o_gen_hdr, o_gen_data, o_gen_idle,
                                        o_gen_ifg, o_gen_error}), 1);
            if (!i_clk_en) begin
                check("gated_pulses", {o_buf_rd, o_frame_done, o_underrun}, 0);
                continue;
            end
            kind = o_gen_hdr ? 1 : o_gen_data ? 2 : o_gen_ifg ? 3 : o_gen_error ? 4 : 0;
            if (b2b_due)
                check("b2b_hdr", o_gen_hdr, 1);
            b2b_due = 1'b0;
            if (o_gen_ifg) begin
                ifg_run++;
                if (ifg_run == IFGW && i_tx_en && i_frame_rdy)
                    b2b_due = 1'b1;
            end else begin
                ifg_run = 0;
            end
            if (kind == 0 && !o_buf_rd && !o_frame_done && !o_underrun)
                continue;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out kind=%0d pop=%0d required=none", kind, o_buf_rd);
                continue;
            end
            t = exp_q.pop_front();
            check("kind", kind, t.kind);
            check("pop", o_buf_rd, t.pop);
            check("done", o_frame_done, t.done);
            check("underrun", o_underrun, t.und);
            check("busy", o_busy, 1);
            check("frame_cnt", o_frame_cnt, t.cnt);
            if (t.kind == 1)
                check("hdr_id", o_hdr_id, t.id);
        end
    end

    initial begin
        int n, r, e, u, nfr;
        bit und_used;
        bit seen;

        #2 i_reset_n = 1'b0;
        #6;
        check("rst_idle", o_gen_idle, 1);
        check("rst_strobes", {o_gen_hdr, o_gen_data, o_gen_ifg, o_gen_error}, 0);
        check("rst_pulses", {o_buf_rd, o_frame_done, o_underrun}, 0);
        check("rst_busy", o_busy, 0);
        check("rst_cnt", o_frame_cnt, 0);
        check("rst_hdr_id", o_hdr_id, 0);
        @(negedge i_clk);
        #3 i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);
        #3;

        load_frame(3, -1, -1);
        drain(200);
        check("t1_cnt", o_frame_cnt, good_cnt % CMOD);

        load_frame(3, -1, -1);
        load_frame(2, -1, -1);
        drain(200);
        check("t2_cnt", o_frame_cnt, good_cnt % CMOD);

        load_frame(4, -1, 2);
        drain(200);
        check("t3_cnt", o_frame_cnt, good_cnt % CMOD);

        load_frame(3, 1, -1);
        load_frame(3, 2, -1);
        drain(200);
        check("t4_cnt", o_frame_cnt, good_cnt % CMOD);

        en_mode = 1;
        load_frame(3, -1, -1);
        drain(300);
        check("t5_cnt", o_frame_cnt, good_cnt % CMOD);

        en_mode = 2;
        tx_rand = 1'b1;
        for (int b = 0; b < 14; b++) begin
            nfr = $urandom_range(1, 3);
            und_used = 1'b0;
            for (int f = 0; f < nfr; f++) begin
                n = $urandom_range(1, 6);
                r = $urandom % 5;
                e = -1;
                u = -1;
                if (r == 0) begin
                    e = $urandom_range(0, n - 1);
                end else if (r == 1 && !und_used) begin
                    u = $urandom_range(0, n - 1);
                    und_used = 1'b1;
                end
                load_frame(n, e, u);
            end
            drain(800);
            check("rand_cnt", o_frame_cnt, good_cnt % CMOD);
        end

        en_mode = 0;
        tx_rand = 1'b0;
        load_frame(8, -1, -1);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge i_clk);
            #3;
            seen = o_gen_data;
        end
        check("t6_reach_data", seen, 1);
        i_reset_n = 1'b0;
        #1;
        check("t6_idle", o_gen_idle, 1);
        check("t6_rd", o_buf_rd, 0);
        check("t6_cnt", o_frame_cnt, 0);
        check("t6_busy", o_busy, 0);
        exp_q.delete();
        buf_q.delete();
        vis_lim = -1;
        rel_cd = 0;
        good_cnt = 0;
        @(negedge i_clk);
        #3 i_reset_n = 1'b1;
        load_frame(3, -1, -1);
        drain(200);
        check("t6_post_cnt", o_frame_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
